lsu_unit: RTL

//  Load/store unit directly downstream of the execute stage. Takes the EXU address (alu_result),
//  rs2 store data and the decoded access type; runs one access on the data-memory req/resp bus.

---
 rtl/lsu_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lsu_unit.sv
// lsu_unit: single-outstanding load/store unit between execute and the data-memory bus.
// Lane-aligns store data, extracts and extends load data, flags misalignment and bus timeouts.
module lsu_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_wen,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        lsu_busy,
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic        lsu_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          wen_q;
    logic [2:0]    f3_q;
    logic [31:0]   addr_q, wdata_q, rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bad, tmo, req;
    logic [4:0]    lane;
    logic [15:0]   sh;
    logic [31:0]   ext;

    assign bad = !(in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
               || (in_funct3[1:0] == 2'b01 && in_addr[0])
               || (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
    assign tmo  = cnt_q >= CW'(TIMEOUT - 1);
    assign lane = {addr_q[1:0], 3'b000};
    assign sh   = 16'(mem_rdata >> lane);
    assign ext  = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]}
                : f3_q == 3'b001 ? {{16{sh[15]}}, sh}
                : f3_q == 3'b100 ? {24'b0, sh[7:0]}
                : f3_q == 3'b101 ? {16'b0, sh}
                : mem_rdata;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = bad ? DONE : REQ;
                err_d   = bad;
                rdata_d = '0;
                cnt_d   = '0;
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_req_ready) state_d = WAIT;
                else if (tmo) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_resp_valid) begin
                    state_d = DONE;
                    rdata_d = wen_q ? '0 : ext;
                end else if (tmo) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && in_valid) begin
                wen_q   <= in_wen;
                f3_q    <= in_funct3;
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
            end
        end
    end

    // Request and completion are gated by rst so they drop in the cycle reset is asserted.
    assign req           = state_q == REQ && rst;
    assign lsu_busy      = state_q != IDLE;
    assign out_valid     = state_q == DONE && rst;
    assign out_rdata     = out_valid ? rdata_q : '0;
    assign lsu_err       = out_valid && err_q;
    assign mem_req_valid = req;
    assign mem_addr      = req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wen       = req && wen_q;
    assign mem_wstrb     = !mem_wen ? 4'b0000
                         : f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
                         : f3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0]
                         : 4'b1111;
    assign mem_wdata     = mem_wen ? wdata_q << lane : '0;
endmodule
